score_digits_render: RTL and testbench
======================================

Name: score_digits_render

Overview:
- Parametrised successor to the single-digit renderer: converts a binary score to BCD sequentially and draws NUM_DIGITS glyphs in a horizontal row on the VGA raster.
- Sits between game logic (score source) and the pixel mux. Drives a registered 6-bit RRGGBB pixel.
- Displayed digits change only at frame boundaries, so the score never tears mid-frame.

Parameters:
- NUM_DIGITS, 5, number of decimal digits drawn (1..6).
- SCORE_W, 17, width of the binary score input.
- X0, 20, left edge of digit 0 (most significant); glyph i columns are (X0+i*PITCH, X0+i*PITCH+25].
- Y0, 70, top edge; glyph rows are (Y0, Y0+40].
- PITCH, 26, column distance between digit origins (must be ≥ 26).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- score_load  in  1  one-cycle request to convert score
- score  in  SCORE_W  binary score, sampled when score_load is accepted
- busy  out  1  conversion in progress
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- col  in  10  current pixel column
- row  in  10  current pixel row
- valid  in  1  pixel is in the visible area
- fg_color  in  6  glyph colour
- digit_rgb  out  6  pixel colour; 6'b000000 where no glyph is lit

Behaviour:
- Reset values: busy=0, digit_rgb=0, shadow and display BCD registers all zero (display shows 0…0), pending flag=0.
- Accepting a load: score_load while busy=0 in cycle T captures score and sets busy=1 at T+1.
- Conversion: shift-add-3 (double dabble), one shift per cycle for SCORE_W cycles.
  - The shadow BCD register is written at T+SCORE_W+1.
  - busy falls in that same cycle.
- Saturation: if the captured score > 10^NUM_DIGITS−1, the shadow result is all 9s. The compare is done at capture.
- Load while busy: the score is held in a one-deep pending register; a later load overwrites it (last wins).
  - When the current conversion finishes, the pending conversion starts the next cycle and busy stays 1.
  - Pending is cleared when that conversion starts.
- Frame update: on frame_start, the display register is loaded from the shadow register.
  - If the shadow write and frame_start fall in the same cycle, the display takes the old shadow value.
  - The new value appears at the next frame_start.
- Reset mid-conversion: the conversion is aborted, pending is discarded, and all registers return to reset values.
- Rendering, with off = X0 + i*PITCH for glyph i:
  - Row sections relative to Y0: A (0,10], B (10,15], C (15,25], D (25,30], E (30,40].
  - Stroke columns: L = (off, off+10], R = (off+15, off+25], F = (off, off+25].
  - Glyph table, listed as sections A,B,C,D,E:
    - 0: F, L+R, L+R, L+R, F
    - 1: R, R, R, R, R
    - 2: F, R, F, L, F
    - 3: F, R, F, R, F
    - 4: L+R, L+R, F, R, R
    - 5: F, L, F, R, F
    - 6: F, L, F, L+R, F
    - 7: F, R, R, R, R
    - 8: F, L+R, F, L+R, F
    - 9: F, L+R, F, R, F
- Pixel output: a lit pixel gives digit_rgb = fg_color; otherwise 0.
  - Pixels outside all glyph boxes, or with valid=0, give 0.
- Latency: digit_rgb is registered, one cycle after col/row/valid/fg_color.
- Arithmetic: all column and row bounds are computed at 11 bits, so no wrap occurs at the 10-bit edge.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digits more significant than the first nonzero display digit render black. Digit NUM_DIGITS−1 is always drawn, so a score of 0 shows a single "0". Blanking uses the display register, not the shadow register.
- Undefined: all NUM_DIGITS digits are always drawn, with leading zeros.

Test Plan:
- Reset, then raster pixel (col=X0+5, row=Y0+5, valid=1, fg_color=6'b111111) -> digit_rgb=6'b111111 one cycle later, since digit 0 is "0" and section A is F.
- Load 12345, wait SCORE_W+1 cycles, pulse frame_start -> busy=1 for exactly 17 cycles; digits read 1,2,3,4,5. Sample col=X0+26+5, row=Y0+12 (digit 1 = "2", section B, L column) -> 0.
- Load 123456 (exceeds 99999) -> display 99999 after frame_start.
- Load 100 while busy with 50, then load 7 -> after both conversions and frame_start, the display shows 00007.
- Shadow write coincident with frame_start -> display keeps the old value until the next frame_start.
- valid=0 over a lit glyph pixel -> digit_rgb=0. With LEADING_ZERO_BLANK_EN and score 42: digits 0–2 black, "42" drawn.

Source files
------------

// File: rtl/score_digits_render.sv
// Sequential double-dabble score converter plus NUM_DIGITS glyph renderer with frame-synchronous display update.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (the last digit is always drawn).
module score_digits_render #(
    parameter int NUM_DIGITS = 5,
    parameter int SCORE_W    = 17,
    parameter int X0         = 20,
    parameter int Y0         = 70,
    parameter int PITCH      = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               score_load,
    input  logic [SCORE_W-1:0] score,
    output logic               busy,
    input  logic               frame_start,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    input  logic               valid,
    input  logic [5:0]         fg_color,
    output logic [5:0]         digit_rgb
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [10:0] Y0_11 = 11'(Y0);

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < n; k++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

    // Per digit, five 3-bit section codes {A,B,C,D,E}; code bits are {middle, right, left}.
    function automatic logic [14:0] glyph_pattern(input logic [3:0] d);
        case (d)
            4'd0:    glyph_pattern = {3'b111, 3'b011, 3'b011, 3'b011, 3'b111};
            4'd1:    glyph_pattern = {3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
            4'd2:    glyph_pattern = {3'b111, 3'b010, 3'b111, 3'b001, 3'b111};
            4'd3:    glyph_pattern = {3'b111, 3'b010, 3'b111, 3'b010, 3'b111};
            4'd4:    glyph_pattern = {3'b011, 3'b011, 3'b111, 3'b010, 3'b010};
            4'd5:    glyph_pattern = {3'b111, 3'b001, 3'b111, 3'b010, 3'b111};
            4'd6:    glyph_pattern = {3'b111, 3'b001, 3'b111, 3'b011, 3'b111};
            4'd7:    glyph_pattern = {3'b111, 3'b010, 3'b010, 3'b010, 3'b010};
            4'd8:    glyph_pattern = {3'b111, 3'b011, 3'b111, 3'b011, 3'b111};
            4'd9:    glyph_pattern = {3'b111, 3'b011, 3'b111, 3'b010, 3'b111};
            default: glyph_pattern = 15'd0;
        endcase
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               pend_v_q, pend_v_d;
    logic [SCORE_W-1:0] pend_score_q, pend_score_d;
    logic [BCD_W-1:0]   shadow_q, shadow_d;
    logic [BCD_W-1:0]   display_q, display_d;
    logic [5:0]         pixel_q, pixel_d;

    logic [BCD_W-1:0]   bcd_adj, bcd_shift;
    logic [SCORE_W-1:0] bin_shift, start_score;
    logic               start_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_score_q <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pixel_q      <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            pend_v_q     <= pend_v_d;
            pend_score_q <= pend_score_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pixel_q      <= pixel_d;
        end
    end

    // The last shift writes the shadow directly from the combinational result, so busy drops with the write.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        pend_v_d     = pend_v_q;
        pend_score_d = pend_score_q;
        shadow_d     = shadow_q;
        start_en     = 1'b0;
        start_score  = score;

        bcd_adj = bcd_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_shift = {bin_q[SCORE_W-2:0], 1'b0};

        case (state_q)
            S_IDLE: begin
                if (score_load) start_en = 1'b1;
            end
            S_CONV: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 1'b1;
                if (score_load) begin
                    pend_v_d     = 1'b1;
                    pend_score_d = score;
                end
                if (cnt_q == LAST_SHIFT) begin
                    shadow_d = sat_q ? ALL_NINES : bcd_shift;
                    if (score_load || pend_v_q) begin
                        start_en    = 1'b1;
                        start_score = score_load ? score : pend_score_q;
                        pend_v_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_en) begin
            state_d = S_CONV;
            bin_d   = start_score;
            bcd_d   = '0;
            cnt_d   = '0;
            sat_d   = (64'(start_score) > MAX_VAL);
        end
    end

    always_comb begin
        display_d = frame_start ? shadow_q : display_q;
    end

    logic [10:0] col_x, row_y, row_rel, off, col_rel;
    logic [2:0]  sec;
    logic [2:0]  code;
    logic [3:0]  digit;
    logic [14:0] pat;
    logic        row_in, col_in, in_l, in_m, in_r, lit, seen, blank;

    // Bounds are widened to 11 bits so glyphs near column 1023 never wrap.
    always_comb begin
        col_x   = {1'b0, col};
        row_y   = {1'b0, row};
        row_rel = row_y - Y0_11;
        row_in  = (row_y > Y0_11) && (row_y <= Y0_11 + 11'd40);
        if (row_rel <= 11'd10)      sec = 3'd0;
        else if (row_rel <= 11'd15) sec = 3'd1;
        else if (row_rel <= 11'd25) sec = 3'd2;
        else if (row_rel <= 11'd30) sec = 3'd3;
        else                        sec = 3'd4;

        lit     = 1'b0;
        seen    = 1'b0;
        blank   = 1'b0;
        off     = '0;
        col_rel = '0;
        col_in  = 1'b0;
        in_l    = 1'b0;
        in_m    = 1'b0;
        in_r    = 1'b0;
        digit   = '0;
        pat     = '0;
        code    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = display_q[4*(NUM_DIGITS-1-i) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (digit != 4'd0) seen = 1'b1;
            blank = !seen && (i != NUM_DIGITS - 1);
`else
            blank = 1'b0;
`endif
            off     = 11'(X0 + i * PITCH);
            col_rel = col_x - off;
            col_in  = (col_x > off) && (col_rel <= 11'd25);
            in_l    = (col_rel <= 11'd10);
            in_m    = (col_rel > 11'd10) && (col_rel <= 11'd15);
            in_r    = (col_rel > 11'd15);
            pat     = glyph_pattern(digit);
            code    = pat[3*(3'd4 - sec) +: 3];
            if (row_in && col_in && !blank &&
                ((code[0] && in_l) || (code[1] && in_r) || (code[2] && in_m)))
                lit = 1'b1;
        end
        pixel_d = (valid && lit) ? fg_color : 6'b000000;
    end

    assign busy      = (state_q == S_CONV);
    assign digit_rgb = pixel_q;

endmodule

// File: tb/tb_score_digits_render.sv
// Directed self-checking bench for score_digits_render: conversion timing, pending loads, frame sync and glyph raster.
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the build.
module tb_score_digits_render;

    localparam int NUM_DIGITS = 5;
    localparam int SCORE_W    = 17;
    localparam int X0         = 20;
    localparam int Y0         = 70;
    localparam int PITCH      = 26;

    localparam logic [2:0] GF  = 3'b111;
    localparam logic [2:0] GLR = 3'b011;
    localparam logic [2:0] GL  = 3'b001;
    localparam logic [2:0] GR  = 3'b010;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               score_load;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               frame_start;
    logic [9:0]         col;
    logic [9:0]         row;
    logic               valid;
    logic [5:0]         fg_color;
    logic [5:0]         digit_rgb;

    int checkCount = 0;
    int errorCount = 0;

    score_digits_render #(
        .NUM_DIGITS(NUM_DIGITS), .SCORE_W(SCORE_W), .X0(X0), .Y0(Y0), .PITCH(PITCH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .score_load(score_load), .score(score), .busy(busy),
        .frame_start(frame_start), .col(col), .row(row), .valid(valid),
        .fg_color(fg_color), .digit_rgb(digit_rgb)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int c, input int r, input logic v, input logic [5:0] fg);
        col      = 10'(c);
        row      = 10'(r);
        valid    = v;
        fg_color = fg;
        tick();
    endtask

    task automatic pixelCheck(input string tag, input int c, input int r, input logic v,
                              input logic [5:0] fg, input logic [5:0] expected);
        applyStimulus(c, r, v, fg);
        checkOutput(tag, 32'(digit_rgb), 32'(expected));
    endtask

    task automatic loadScore(input int value);
        score_load = 1'b1;
        score      = SCORE_W'(value);
        tick();
        score_load = 1'b0;
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [14:0] expGlyph(input logic [3:0] d);
        case (d)
            4'd0:    expGlyph = {GF,  GLR, GLR, GLR, GF};
            4'd1:    expGlyph = {GR,  GR,  GR,  GR,  GR};
            4'd2:    expGlyph = {GF,  GR,  GF,  GL,  GF};
            4'd3:    expGlyph = {GF,  GR,  GF,  GR,  GF};
            4'd4:    expGlyph = {GLR, GLR, GF,  GR,  GR};
            4'd5:    expGlyph = {GF,  GL,  GF,  GR,  GF};
            4'd6:    expGlyph = {GF,  GL,  GF,  GLR, GF};
            4'd7:    expGlyph = {GF,  GR,  GR,  GR,  GR};
            4'd8:    expGlyph = {GF,  GLR, GF,  GLR, GF};
            4'd9:    expGlyph = {GF,  GLR, GF,  GR,  GF};
            default: expGlyph = 15'd0;
        endcase
    endfunction

    function automatic int sectionRow(input int s);
        case (s)
            0:       sectionRow = 5;
            1:       sectionRow = 12;
            2:       sectionRow = 20;
            3:       sectionRow = 27;
            default: sectionRow = 35;
        endcase
    endfunction

    // Probes left/right/middle strokes in every section of each glyph and compares the lit map to the table.
    task automatic checkDisplay(input string tag, input logic [19:0] expBcd);
        logic [14:0] expPat;
        logic [14:0] obsPat;
        logic [3:0]  d;
        logic        seen;
        int          colOff;
        seen = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d      = expBcd[4*(NUM_DIGITS-1-i) +: 4];
            expPat = expGlyph(d);
`ifdef LEADING_ZERO_BLANK_EN
            if (d != 4'd0) seen = 1'b1;
            if (!seen && i != NUM_DIGITS - 1) expPat = 15'd0;
`endif
            obsPat = 15'd0;
            for (int s = 0; s < 5; s++) begin
                for (int z = 0; z < 3; z++) begin
                    colOff = (z == 0) ? 5 : ((z == 1) ? 20 : 12);
                    applyStimulus(X0 + i * PITCH + colOff, Y0 + sectionRow(s), 1'b1, 6'h3F);
                    obsPat[3*(4-s)+z] = (digit_rgb == 6'h3F);
                end
            end
            checkOutput($sformatf("%s_digit%0d", tag, i), 32'(obsPat), 32'(expPat));
        end
    endtask

    initial begin
        int busyCycles;
        logic [5:0] firstPixel;

        rst_n       = 1'b0;
        score_load  = 1'b0;
        score       = '0;
        frame_start = 1'b0;
        col         = '0;
        row         = '0;
        valid       = 1'b0;
        fg_color    = '0;
        tick();
        tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rgb", 32'(digit_rgb), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef LEADING_ZERO_BLANK_EN
        firstPixel = 6'h00;
`else
        firstPixel = 6'h3F;
`endif
        pixelCheck("reset_digit0_A", X0 + 5, Y0 + 5, 1'b1, 6'h3F, firstPixel);
        checkDisplay("reset", 20'h00000);

        $display("[TB] load 12345");
        loadScore(12345);
        countBusy(busyCycles);
        checkOutput("busy_len_12345", 32'(busyCycles), 32'd17);
        pixelCheck("pre_frame_digit4", X0 + 4 * PITCH + 20, Y0 + 12, 1'b1, 6'h3F, 6'h3F);
        pulseFrame();
        pixelCheck("digit1_B_left", X0 + 26 + 5, Y0 + 12, 1'b1, 6'h3F, 6'h00);
        checkDisplay("d12345", 20'h12345);

        $display("[TB] load 123456 (saturates)");
        loadScore(123456);
        waitIdle("timeout_sat", 40);
        pulseFrame();
        checkDisplay("sat", 20'h99999);

        $display("[TB] pending loads 50, 100, 7");
        loadScore(50);
        loadScore(100);
        loadScore(7);
        countBusy(busyCycles);
        checkOutput("busy_len_pending", 32'(busyCycles), 32'd32);
        pulseFrame();
        checkDisplay("pending", 20'h00007);

        $display("[TB] shadow write coincident with frame_start");
        loadScore(42);
        repeat (16) tick();
        checkOutput("busy_before_write", 32'(busy), 32'd1);
        pulseFrame();
        checkOutput("busy_after_write", 32'(busy), 32'd0);
        checkDisplay("coincident_old", 20'h00007);
        pulseFrame();
        checkDisplay("coincident_new", 20'h00042);

        pixelCheck("bound_col_left_excl", X0 + 3 * PITCH,      Y0 + 20, 1'b1, 6'h3F, 6'h00);
        pixelCheck("bound_col_left_incl", X0 + 3 * PITCH + 1,  Y0 + 20, 1'b1, 6'h3F, 6'h3F);
        pixelCheck("bound_col_right_incl", X0 + 3 * PITCH + 25, Y0 + 20, 1'b1, 6'h3F, 6'h3F);
        pixelCheck("bound_col_gap",       X0 + 4 * PITCH,      Y0 + 20, 1'b1, 6'h3F, 6'h00);
        pixelCheck("bound_row_top_excl",  X0 + 4 * PITCH + 5, Y0,      1'b1, 6'h3F, 6'h00);
        pixelCheck("bound_row_top_incl",  X0 + 4 * PITCH + 5, Y0 + 1,  1'b1, 6'h3F, 6'h3F);
        pixelCheck("bound_row_bot_incl",  X0 + 4 * PITCH + 5, Y0 + 40, 1'b1, 6'h3F, 6'h3F);
        pixelCheck("bound_row_bot_excl",  X0 + 4 * PITCH + 5, Y0 + 41, 1'b1, 6'h3F, 6'h00);
        pixelCheck("section_B_mid",       X0 + 3 * PITCH + 12, Y0 + 15, 1'b1, 6'h3F, 6'h00);
        pixelCheck("section_C_mid",       X0 + 3 * PITCH + 12, Y0 + 16, 1'b1, 6'h3F, 6'h3F);
        pixelCheck("far_right",           1023,                Y0 + 5,  1'b1, 6'h3F, 6'h00);
        pixelCheck("valid_low",           X0 + 4 * PITCH + 5, Y0 + 5,  1'b0, 6'h3F, 6'h00);
        pixelCheck("fg_colour",           X0 + 4 * PITCH + 5, Y0 + 5,  1'b1, 6'h2A, 6'h2A);

        $display("[TB] reset mid-conversion");
        loadScore(999);
        repeat (3) tick();
        loadScore(5);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_rgb", 32'(digit_rgb), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        checkOutput("midreset_no_pending", 32'(busy), 32'd0);
        pulseFrame();
        checkDisplay("midreset", 20'h00000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
